// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states, reset address
// default, alignment helper and the opcode/funct constants that the control
// decoder consumes from the fetch stage.
package mips_pkg;

    // Fetch unit state encoding
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'h0000_0004;

    // Primary opcode field values (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct field values (Instr[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, +4 increment (wraps mod 2^32) and
// redirect load. Both the stored value and the next value are word aligned.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inc_i,
    input  logic        load_i,
    input  logic [31:0] load_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_d_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // Next PC: redirect load beats increment, otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_pc_i);
        end else if (inc_i) begin
            pc_d = pc_q + PC_STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o   = pc_q;
    assign pc_d_o = pc_d;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives word reads to instruction memory over a
// req/ack handshake and hands fetched words to decode over valid/ready.
// A redirect retargets the PC; data of a request already in flight is
// dropped (DROP state) so the memory handshake always completes cleanly.
// Every output comes straight from a flop.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset_L,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC
);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic        pc_inc_s;
    logic        pc_load_s;
    logic        accept_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;

    logic        imem_req_q,    imem_req_d;
    logic [31:0] imem_addr_q,   imem_addr_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    // An ack in REQ is kept only when no redirect arrives in the same cycle
    assign accept_s  = (state_q == FS_REQ) && IMemAck && !Redirect;
    assign pc_inc_s  = accept_s;
    assign pc_load_s = Redirect && (state_q != FS_IDLE);

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i     (CLK),
        .rst_n_i   (Reset_L),
        .inc_i     (pc_inc_s),
        .load_i    (pc_load_s),
        .load_pc_i (RedirectPC),
        .pc_o      (pc_s),
        .pc_d_o    (pc_next_s)
    );

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; redirect takes priority in every active state
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE: begin
                state_d = FS_REQ;
            end
            FS_REQ: begin
                if (Redirect) begin
                    state_d = IMemAck ? FS_REQ : FS_DROP;
                end else if (IMemAck) begin
                    state_d = FS_HOLD;
                end else begin
                    state_d = FS_REQ;
                end
            end
            FS_HOLD: begin
                if (Redirect || InstrReady) begin
                    state_d = FS_REQ;
                end else begin
                    state_d = FS_HOLD;
                end
            end
            FS_DROP: begin
                if (IMemAck) begin
                    state_d = FS_REQ;
                end else begin
                    state_d = FS_DROP;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // FSM output logic: next values of the registered outputs
    always_comb begin
        imem_req_d    = (state_d == FS_REQ) || (state_d == FS_DROP);
        instr_valid_d = (state_d == FS_HOLD);
        // A fresh request picks up the new PC; DROP keeps the old address
        if (state_d == FS_REQ) begin
            imem_addr_d = pc_next_s;
        end else begin
            imem_addr_d = imem_addr_q;
        end
        if (accept_s) begin
            instr_d    = IMemData;
            instr_pc_d = pc_s;
        end else begin
            instr_d    = instr_q;
            instr_pc_d = instr_pc_q;
        end
    end

    // Output registers
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            imem_req_q    <= 1'b0;
            imem_addr_q   <= word_align(RESET_PC);
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign IMemReq    = imem_req_q;
    assign IMemAddr   = imem_addr_q;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign InstrValid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level reference model (outstanding
// request, held instruction, next PC) compared on every cycle, plus directed
// scenarios with literal expectations, then a randomized phase.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady;
    logic        Redirect;
    logic [31:0] RedirectPC;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic        m_started;
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_discard;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [31:0] m_pc;

    instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .Instr      (Instr),
        .InstrPC    (InstrPC),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the behavioural model, applied with the inputs seen at the edge
    task automatic model_step();
        logic acked;
        logic was_valid;
        if (!Reset_L) begin
            m_started = 1'b0; m_req = 1'b0; m_addr = RST_PC; m_discard = 1'b0;
            m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0; m_pc = RST_PC;
        end else if (!m_started) begin
            m_started = 1'b1;
            m_req     = 1'b1;
            m_addr    = m_pc;
        end else begin
            acked     = m_req && IMemAck;
            was_valid = m_valid;
            if (was_valid && (InstrReady || Redirect)) m_valid = 1'b0;
            if (acked) begin
                if (!m_discard && !Redirect) begin
                    m_valid = 1'b1;
                    m_instr = IMemData;
                    m_ipc   = m_addr;
                    m_pc    = m_addr + 32'd4;
                end
                m_req     = 1'b0;
                m_discard = 1'b0;
            end else if (m_req && Redirect) begin
                m_discard = 1'b1;
            end
            if (Redirect) m_pc = {RedirectPC[31:2], 2'b00};
            if (!m_req && !m_valid) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    // Compare process: model step at each edge, DUT sampled 1 time unit later
    initial begin
        forever begin
            @(posedge CLK);
            model_step();
            #1;
            chk("m_req",   {31'd0, IMemReq},    {31'd0, m_req});
            chk("m_valid", {31'd0, InstrValid}, {31'd0, m_valid});
            chk("m_instr", Instr,   m_instr);
            chk("m_ipc",   InstrPC, m_ipc);
            if (m_req || !m_started) chk("m_addr", IMemAddr, m_addr);
        end
    end

    // Apply inputs (called at a falling edge) and wait for the next falling edge
    task automatic cyc(input logic r, input logic a, input logic [31:0] d,
                       input logic rdy, input logic rd, input logic [31:0] rpc);
        Reset_L = r; IMemAck = a; IMemData = d; InstrReady = rdy;
        Redirect = rd; RedirectPC = rpc;
        @(negedge CLK);
    endtask

    initial begin
        Reset_L = 1'b0; IMemAck = 1'b0; IMemData = 32'h0; InstrReady = 1'b0;
        Redirect = 1'b0; RedirectPC = 32'h0;
        @(negedge CLK);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_req",   {31'd0, IMemReq}, 32'd0);
        chk("rst_addr",  IMemAddr, 32'h0000_0100);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_valid", {31'd0, InstrValid}, 32'd0);

        // release: IDLE then REQ at RESET_PC
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("first_req",  {31'd0, IMemReq}, 32'd1);
        chk("first_addr", IMemAddr, 32'h0000_0100);
        cyc(1'b1, 1'b1, 32'h8C01_0004, 1'b0, 1'b0, 32'h0);
        chk("lw_instr", Instr, 32'h8C01_0004);
        chk("lw_pc",    InstrPC, 32'h0000_0100);
        chk("lw_valid", {31'd0, InstrValid}, 32'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("next_addr", IMemAddr, 32'h0000_0104);

        // 3 wait cycles, then 4 cycles of InstrReady low
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("wait_addr", IMemAddr, 32'h0000_0104);
        end
        cyc(1'b1, 1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("hold_instr", Instr, 32'h2001_0005);
            chk("hold_noreq", {31'd0, IMemReq}, 32'd0);
            cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("after_hold_addr", IMemAddr, 32'h0000_0108);

        // redirect in REQ without ack -> DROP, late data discarded
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
        chk("drop_addr", IMemAddr, 32'h0000_0108);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        chk("drop_novalid", {31'd0, InstrValid}, 32'd0);
        chk("redir_addr",   IMemAddr, 32'h0000_0200);

        // redirect in HOLD with InstrReady high
        cyc(1'b1, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0);
        chk("hold200_pc", InstrPC, 32'h0000_0200);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0043);
        chk("hold_redir_valid", {31'd0, InstrValid}, 32'd0);
        chk("hold_redir_addr",  IMemAddr, 32'h0000_0040);

        // redirect with ack in REQ, then wrap past 0xFFFF_FFFC
        cyc(1'b1, 1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'hFFFF_FFFE);
        chk("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 32'h0800_0000, 1'b0, 1'b0, 32'h0);
        chk("wrap_ipc", InstrPC, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap_next", IMemAddr, 32'h0000_0000);

        // reset during DROP, then a late ack right after release
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("mid_rst_req",  {31'd0, IMemReq}, 32'd0);
        chk("mid_rst_addr", IMemAddr, 32'h0000_0100);
        chk("mid_rst_ipc",  InstrPC, 32'h0);
        cyc(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        chk("late_ack_valid", {31'd0, InstrValid}, 32'd0);
        chk("late_ack_addr",  IMemAddr, 32'h0000_0100);

        // randomized phase, model checks every cycle
        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic        a;
            logic        rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 199) != 0);
            a   = m_req && ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            cyc(r, a, $urandom, ($urandom_range(0, 1) == 1), rd, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
